// File: rtl/code_ser_pkg.sv
// Shared types and constants for the code serializer and the benches that drive it.
package code_ser_pkg;

   typedef enum logic {IDLE, SHIFT} ser_state_e;

   localparam int CODE_WIDTH_DEF = 3;
   localparam int FIFO_DEPTH_DEF = 4;

   localparam logic [2:0] CODE_010 = 3'b010;
   localparam logic [2:0] CODE_110 = 3'b110;

endpackage

// File: rtl/code_serializer_fifo.sv
// Synchronous FIFO with an extra pointer bit to tell full from empty.
module sync_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + (AW+1)'(1);
         if (do_pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rptr[AW-1:0]];
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/code_serializer.sv
// Buffers parallel codewords and shifts them out MSB-first, gapless, with a frame
// marker on the first bit of each word.
module code_serializer
   import code_ser_pkg::*;
#(
   parameter int   WIDTH    = CODE_WIDTH_DEF,
   parameter int   DEPTH    = FIFO_DEPTH_DEF,
   parameter logic IDLE_BIT = 1'b1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             code_valid,
   input  logic [WIDTH-1:0] code_data,
   output logic             code_ready,
   output logic             ser_out,
   output logic             ser_frame,
   output logic             ser_busy,
   output logic [7:0]       words_sent
);

   localparam int BCW = $clog2(WIDTH);

   ser_state_e       state;
   ser_state_e       state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] head;
   logic [BCW-1:0]   bit_cnt;
   logic             full;
   logic             empty;
   logic             push;
   logic             load;
   logic             shift;
   logic             out_nxt;
   logic             frame_nxt;
   logic             busy_nxt;

   assign code_ready = !full && rstn;
   assign push       = code_valid && code_ready;
   assign shift      = (state == SHIFT) && (bit_cnt != '0);

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .wdata (code_data),
      .pop   (load),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         ser_out    <= IDLE_BIT;
         ser_frame  <= 1'b0;
         ser_busy   <= 1'b0;
         words_sent <= '0;
      end else begin
         state     <= state_nxt;
         ser_out   <= out_nxt;
         ser_frame <= frame_nxt;
         ser_busy  <= busy_nxt;
         if (load) begin
            shreg      <= head;
            bit_cnt    <= BCW'(WIDTH-1);
            words_sent <= words_sent + 8'd1;
         end else if (shift) begin
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt - BCW'(1);
         end
      end
   end

   // A load on the last bit of a word keeps the stream gapless.
   always_comb begin
      load      = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!empty) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (bit_cnt == '0) begin
               if (!empty) load = 1'b1;
               else        state_nxt = IDLE;
            end
         end
      endcase
   end

   // shreg[WIDTH-1] is already on the line, so the next bit is one below it.
   always_comb begin
      out_nxt   = IDLE_BIT;
      frame_nxt = 1'b0;
      busy_nxt  = 1'b0;
      if (load) begin
         out_nxt   = head[WIDTH-1];
         frame_nxt = 1'b1;
         busy_nxt  = 1'b1;
      end else if (shift) begin
         out_nxt  = shreg[WIDTH-2];
         busy_nxt = 1'b1;
      end
   end

endmodule

// File: tb/tb_code_serializer.sv
// Directed bench for code_serializer: single word, back-to-back, fill, reset, wrap, idle.
module tb_code_serializer;
   import code_ser_pkg::*;

   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         code_valid = 1'b0;
   logic [W-1:0] code_data = '0;
   logic         code_ready;
   logic         ser_out;
   logic         ser_frame;
   logic         ser_busy;
   logic [7:0]   words_sent;

   int n_chk = 0;
   int n_pass = 0;

   code_serializer #(
      .WIDTH    (W),
      .DEPTH    (4),
      .IDLE_BIT (1'b1)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .code_valid (code_valid),
      .code_data  (code_data),
      .code_ready (code_ready),
      .ser_out    (ser_out),
      .ser_frame  (ser_frame),
      .ser_busy   (ser_busy),
      .words_sent (words_sent)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
   endtask

   task automatic do_reset();
      code_valid = 1'b0;
      rstn       = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out",   32'(ser_out),    1);
      chk("rst_frame", 32'(ser_frame),  0);
      chk("rst_busy",  32'(ser_busy),   0);
      chk("rst_words", 32'(words_sent), 0);
      chk("rst_ready", 32'(code_ready), 0);
      rstn = 1'b1;
   endtask

   // Called at the negedge where the first bit is on the line.
   task automatic chk_stream(input string tag, input logic [31:0] bits,
                             input logic [31:0] frames, input int n);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_bit"},  32'(ser_out),   32'(bits[n-1-i]));
         chk({tag, "_frm"},  32'(ser_frame), 32'(frames[n-1-i]));
         chk({tag, "_busy"}, 32'(ser_busy),  1);
         @(negedge clk);
      end
      chk({tag, "_idle_out"},  32'(ser_out),  1);
      chk({tag, "_idle_busy"}, 32'(ser_busy), 0);
   endtask

   initial begin
      int          pushed;
      int          drop_at;
      int          nbits;
      int          first;
      int          last;
      int          frames;
      int          bad;
      logic [31:0] got;

      // single word
      do_reset();
      @(negedge clk); code_valid = 1'b1; code_data = CODE_010;
      @(negedge clk); code_valid = 1'b0;
      chk("s1_pre_out",  32'(ser_out),  1);
      chk("s1_pre_busy", 32'(ser_busy), 0);
      @(negedge clk);
      chk_stream("s1", 32'b010, 32'b100, 3);
      chk("s1_words", 32'(words_sent), 1);

      // back-to-back
      do_reset();
      @(negedge clk); code_valid = 1'b1; code_data = CODE_010;
      @(negedge clk); code_data = CODE_110;
      @(negedge clk); code_valid = 1'b0;
      chk_stream("b2b", 32'b010110, 32'b100100, 6);
      chk("b2b_words", 32'(words_sent), 2);

      // fill to full with words 001..111
      do_reset();
      pushed = 0; drop_at = -1; nbits = 0; first = -1; last = -1; frames = 0; got = '0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (ser_busy) begin
            got = {got[30:0], ser_out};
            nbits++;
            if (first < 0) first = k;
            last = k;
            if (ser_frame) frames++;
         end
         if (pushed < 7) begin
            code_valid = 1'b1;
            code_data  = W'(pushed + 1);
            if (code_ready) pushed++;
            else if (drop_at < 0) drop_at = pushed;
         end else begin
            code_valid = 1'b0;
         end
      end
      chk("fill_drop_at", 32'(drop_at), 6);
      chk("fill_pushed",  32'(pushed),  7);
      chk("fill_nbits",   32'(nbits),   21);
      chk("fill_gapless", 32'(last - first + 1), 21);
      chk("fill_frames",  32'(frames),  7);
      chk("fill_bits",    got, {11'b0, 21'b001_010_011_100_101_110_111});
      chk("fill_words",   32'(words_sent), 7);

      // reset mid-word
      do_reset();
      @(negedge clk); code_valid = 1'b1; code_data = CODE_110;
      @(negedge clk); code_data = CODE_010;
      @(negedge clk); code_valid = 1'b0;
      chk("rm_b1_out", 32'(ser_out),   1);
      chk("rm_b1_frm", 32'(ser_frame), 1);
      @(negedge clk);
      chk("rm_b2_out", 32'(ser_out),   1);
      chk("rm_b2_frm", 32'(ser_frame), 0);
      rstn = 1'b0;
      #1;
      chk("rm_ready_low", 32'(code_ready), 0);
      @(negedge clk);
      chk("rm_out",   32'(ser_out),    1);
      chk("rm_frame", 32'(ser_frame),  0);
      chk("rm_busy",  32'(ser_busy),   0);
      chk("rm_words", 32'(words_sent), 0);
      chk("rm_ready", 32'(code_ready), 0);
      rstn = 1'b1;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (ser_busy || !ser_out) bad++;
      end
      chk("rm_quiet",       32'(bad),        0);
      chk("rm_quiet_words", 32'(words_sent), 0);

      // words_sent wrap: 257 words
      do_reset();
      pushed = 0;
      for (int k = 0; k < 2000 && pushed < 257; k++) begin
         @(negedge clk);
         code_valid = 1'b1;
         code_data  = W'(pushed);
         if (code_ready) pushed++;
      end
      @(negedge clk); code_valid = 1'b0;
      bad = 1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!ser_busy) begin
            bad = 0;
            break;
         end
      end
      chk("wrap_pushed",  32'(pushed),     257);
      chk("wrap_timeout", 32'(bad),        0);
      chk("wrap_words",   32'(words_sent), 1);

      // idle input ignored
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         code_valid = 1'b0;
         code_data  = W'(k);
         chk("idle_out", 32'(ser_out), 1);
      end
      chk("idle_words", 32'(words_sent), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
